score_seg_driver: RTL and testbench

Parametrised score-to-seven-segment driver replacing the fixed three-digit divide/modulo decode between the game processor's score output and the board's seven-segment displays. Converts a WIDTH-bit binary score to DIGITS BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per clock, with no dividers. Adds leading-zero blanking, overflow saturation and a one-deep pending-update buffer. Sits on the `clock` domain next to the processor.

---
 rtl/score_seg_driver.sv | 238 +++++++++++++++++++++++
 tb/tb_score_seg_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_seg_driver.sv
// score_seg_driver
// ----------------
// Converts a WIDTH-bit binary score into DIGITS BCD digits with a sequential
// shift-add-3 (double-dabble) engine, one bit per clock, and drives DIGITS
// active-low seven-segment displays (bit order gfedcba).
//
// Features:
//   - leading-zero blanking (digit 0 is never blanked)
//   - overflow saturation: scores >= 10^DIGITS display as all 9s
//   - one-deep pending-update buffer: a strobe that arrives mid-conversion is
//     held and converted next; a later strobe overwrites an earlier one
//   - optional high-score tracking, enabled by defining HIGH_SCORE_EN
//
// Parameters:
//   WIDTH   binary score width
//   DIGITS  number of decimal digits / displays (1..9)
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high; aborts any conversion
//   score_in     binary score, sampled when score_valid=1
//   score_valid  single-cycle update strobe
//   blank_lz     1 = blank leading zero digits
//   show_high    1 = segments show the high score (HIGH_SCORE_EN only)
//   busy         conversion in progress (stays high across a pending restart)
//   done         one-cycle pulse; new outputs valid in this cycle
//   overflow     last committed score >= 10^DIGITS
//   new_high     one-cycle pulse with done when the high score was replaced
//   bcd_out      committed BCD, digit 0 (units) in [3:0]
//   seg          active-low segments, digit 0 in [6:0]
//
// Latency from the strobe edge to the done cycle is WIDTH+1 clocks.

module score_seg_driver #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      score_in,
    input  logic                  score_valid,
    input  logic                  blank_lz,
    input  logic                  show_high,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  new_high,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]    acc_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_vld_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;
    logic [BW-1:0]    bcd_q;

    logic [BW-1:0]    acc_adj_d;
    logic [WIDTH-1:0] restart_val_d;
    logic             restart_d;

`ifdef HIGH_SCORE_EN
    logic [WIDTH-1:0] score_q;     // binary copy of the score being converted
    logic [WIDTH-1:0] high_q;
    logic [BW-1:0]    high_bcd_q;
    logic             new_high_q;
`endif

    // Add-3 correction on every digit that is 5 or more, ahead of the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign acc_adj_d[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5)
                                        ? acc_q[4*gi +: 4] + 4'd3
                                        : acc_q[4*gi +: 4];
        end
    endgenerate

    // At COMMIT a strobe arriving in that very cycle is the newest value, so
    // it takes precedence over whatever is already pending.
    always_comb begin
        restart_d     = score_valid | pend_vld_q;
        restart_val_d = score_valid ? score_in : pend_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
`ifdef HIGH_SCORE_EN
            score_q    <= '0;
            high_q     <= '0;
            high_bcd_q <= '0;
            new_high_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef HIGH_SCORE_EN
            new_high_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (score_valid) begin
                        bin_q   <= score_in;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= CW'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef HIGH_SCORE_EN
                        score_q <= score_in;
`endif
                    end
                end

                SHIFT: begin
                    // Shift {bcd, bin} left; a 1 leaving the top digit means
                    // the score does not fit in DIGITS decimal digits.
                    acc_q <= {acc_adj_d[BW-2:0], bin_q[WIDTH-1]};
                    bin_q <= bin_q << 1;
                    ovf_q <= ovf_q | acc_adj_d[BW-1];
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= COMMIT;
                    end
                    if (score_valid) begin
                        pend_q     <= score_in;
                        pend_vld_q <= 1'b1;
                    end
                end

                COMMIT: begin
                    bcd_q      <= ovf_q ? NINES : acc_q;
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
`ifdef HIGH_SCORE_EN
                    if (score_q > high_q) begin
                        high_q     <= score_q;
                        high_bcd_q <= ovf_q ? NINES : acc_q;
                        new_high_q <= 1'b1;
                    end
`endif
                    pend_vld_q <= 1'b0;
                    if (restart_d) begin
                        bin_q   <= restart_val_d;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= SHIFT;
`ifdef HIGH_SCORE_EN
                        score_q <= restart_val_d;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Segment decode of whichever BCD value is on display.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [BW-1:0] disp_bcd;

`ifdef HIGH_SCORE_EN
    assign disp_bcd = show_high ? high_bcd_q : bcd_q;
    assign new_high = new_high_q;
`else
    logic unused_show_high;
    assign unused_show_high = show_high;
    assign disp_bcd = bcd_q;
    assign new_high = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
            if (gi == 0) begin : g_units
                assign seg[6:0] = seg7(disp_bcd[3:0]);
            end else begin : g_upper
                // Blank when this digit and every digit above it is zero.
                assign seg[7*gi +: 7] = (blank_lz && (disp_bcd[BW-1:4*gi] == '0))
                                      ? 7'h7F
                                      : seg7(disp_bcd[4*gi +: 4]);
            end
        end
    endgenerate

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign bcd_out  = bcd_q;

endmodule

// File: tb/tb_score_seg_driver.sv
// Randomised self-checking bench for score_seg_driver (WIDTH=32, DIGITS=3).
// Expected values come from a decimal reference model (saturate, divide into
// digits, look up segment codes). High-score checks follow HIGH_SCORE_EN.

module tb_score_seg_driver;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 3;

    logic              clock;
    logic              reset;
    logic [WIDTH-1:0]  score_in;
    logic              score_valid;
    logic              blank_lz;
    logic              show_high;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              new_high;
    logic [11:0]       bcd_out;
    logic [20:0]       seg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [31:0] hi_m;   // model high score (binary)

    score_seg_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clock       (clock),
        .reset       (reset),
        .score_in    (score_in),
        .score_valid (score_valid),
        .blank_lz    (blank_lz),
        .show_high   (show_high),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .new_high    (new_high),
        .bcd_out     (bcd_out),
        .seg         (seg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input logic [31:0] v);
        return (v > 32'd999) ? 999 : int'(v);
    endfunction

    function automatic logic [11:0] model_bcd(input int dv);
        logic [11:0] r;
        r[3:0]  = 4'(dv % 10);
        r[7:4]  = 4'((dv / 10) % 10);
        r[11:8] = 4'((dv / 100) % 10);
        return r;
    endfunction

    function automatic logic [20:0] model_seg(input int dv, input logic bl);
        logic [20:0] r;
        int p;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bl && i > 0 && dv < p)
                r[7*i +: 7] = 7'h7F;
            else
                r[7*i +: 7] = seg_tab[(dv / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    // Strobe one score, wait for done (bounded) and check every output.
    task automatic convert(input logic [31:0] v, input logic bl, input logic sh);
        int lat;
        logic exp_nh;
        int disp;
        @(negedge clock);
        score_in    = v;
        score_valid = 1'b1;
        blank_lz    = bl;
        show_high   = sh;
        @(posedge clock);
        @(negedge clock);
        score_valid = 1'b0;
        check("busy_start", busy, 1'b1);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                lat = c;
                break;
            end
        end
        check("latency", lat, 33);
`ifdef HIGH_SCORE_EN
        exp_nh = (v > hi_m);
        if (exp_nh) hi_m = v;
        disp = sh ? sat(hi_m) : sat(v);
`else
        exp_nh = 1'b0;
        disp = sat(v);
`endif
        check("bcd_out", bcd_out, model_bcd(sat(v)));
        check("overflow", overflow, v > 32'd999);
        check("seg", seg, model_seg(disp, bl));
        check("new_high", new_high, exp_nh);
        check("busy_end", busy, 1'b0);
        $display("[TB] score=%0d blank=%0b show_high=%0b bcd=%h ovf=%0b new_high=%0b seg=%h lat=%0d",
                 v, bl, sh, bcd_out, overflow, new_high, seg, lat);
    endtask

    initial begin
        int dones, lat2, n;
        logic gap;
        logic [11:0] first_bcd, second_bcd;
        logic [31:0] v;

        reset = 1'b1; score_in = '0; score_valid = 1'b0;
        blank_lz = 1'b1; show_high = 1'b0; hi_m = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_bcd", bcd_out, 12'h000);
        check("rst_seg", seg, {7'h7F, 7'h7F, 7'h40});
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_nh", new_high, 1'b0);

        // High-score sequence (new_high on 40 and 60 only with the macro).
        convert(32'd40, 1'b1, 1'b0);
        convert(32'd25, 1'b1, 1'b0);
        convert(32'd60, 1'b1, 1'b0);
        @(negedge clock);
        show_high = 1'b1;
        #1 check("high_seg", seg, {7'h7F, 7'h02, 7'h40});
        show_high = 1'b0;

        // Directed values around the decimal range limit.
        convert(32'd123, 1'b0, 1'b0);
        convert(32'd999, 1'b0, 1'b0);
        convert(32'd1000, 1'b0, 1'b0);
        convert(32'd7, 1'b1, 1'b0);
        convert(32'd0, 1'b1, 1'b0);
        convert(32'hFFFF_FFFF, 1'b1, 1'b0);

        // Randomised scores, blanking and display selection.
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 9);
                1: v = $urandom_range(0, 999);
                2: v = $urandom_range(990, 1010);
                default: v = $urandom;
            endcase
            convert(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Pending buffer: 5, then 7 and 9 during its SHIFT; 7 is dropped.
        @(negedge clock);
        score_in = 32'd5; score_valid = 1'b1; show_high = 1'b0; blank_lz = 1'b0;
        @(posedge clock);
        @(negedge clock);
        score_valid = 1'b0;
        dones = 0; gap = 1'b0; lat2 = 0; first_bcd = '0; second_bcd = '0;
        for (int c = 1; c <= 90; c++) begin
            score_valid = (c == 3) || (c == 8);
            score_in    = (c == 3) ? 32'd7 : 32'd9;
            @(posedge clock);
            @(negedge clock);
            score_valid = 1'b0;
            if (done) begin
                dones++;
                if (dones == 1) first_bcd = bcd_out;
                else if (dones == 2) begin
                    second_bcd = bcd_out;
                    lat2 = c;
                end
            end
            if (dones < 2 && !busy) gap = 1'b1;
        end
        check("pend_dones", dones, 2);
        check("pend_first", first_bcd, 12'h005);
        check("pend_second", second_bcd, 12'h009);
        check("pend_lat2", lat2, 66);
        check("pend_busy_gap", gap, 1'b0);
        $display("[TB] pending: dones=%0d first=%h second=%h second_at=%0d", dones, first_bcd, second_bcd, lat2);
`ifdef HIGH_SCORE_EN
        if (32'd5 > hi_m) hi_m = 32'd5;
        if (32'd9 > hi_m) hi_m = 32'd9;
`endif

        // Reset in the middle of a conversion of 42.
        @(negedge clock);
        score_in = 32'd42; score_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        score_valid = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        hi_m = '0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_bcd", bcd_out, 12'h000);
        check("mid_rst_ovf", overflow, 1'b0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) n++;
        end
        check("mid_rst_nodone", n, 0);
        check("mid_rst_bcd2", bcd_out, 12'h000);
        $display("[TB] reset mid-conversion: busy=%0b bcd=%h dones=%0d", busy, bcd_out, n);

        // Engine usable again after the abort.
        convert(32'd42, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
